// File: rtl/matrix_stream_load.sv
// Stream feeder for matrix_mul: packs 2*SIZE*SIZE doubles into op_a/op_b,
// fires the multiplier, and holds operands until it reports completion.

module matrix_stream_load_elem (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [63:0] d,
  output logic [63:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module matrix_stream_load #(
  parameter int SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [SIZE*SIZE*64-1:0]  op_a,
  output logic [SIZE*SIZE*64-1:0]  op_b,
  output logic                     mul_enable,
  input  logic                     mul_ready,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               count
);
  localparam int N = SIZE * SIZE;
  localparam logic [7:0] LAST = 8'(2*N - 1);

  typedef enum logic [1:0] {S_FILL, S_START, S_ARM, S_BUSY} state_t;
  state_t state, state_nx;

  logic xfer, wr_en, last;
  assign xfer  = in_valid && in_ready;
  assign wr_en = xfer && !clear;
  assign last  = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nx;
  end

  // S_ARM skips mul_ready: a stale high from the previous run is not completion.
  always_comb begin
    state_nx = state;
    case (state)
      S_FILL:  if (wr_en && last) state_nx = S_START;
      S_START: state_nx = S_ARM;
      S_ARM:   state_nx = S_BUSY;
      S_BUSY:  if (mul_ready) state_nx = S_FILL;
      default: state_nx = S_FILL;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_FILL) && !rst;
    mul_enable = (state == S_START) && !rst;
    busy       = (state != S_FILL) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_BUSY) && mul_ready;
      if (state == S_FILL) begin
        if (clear)      count <= '0;
        else if (xfer)  count <= last ? 8'd0 : count + 8'd1;
      end
    end
  end

  // One register per element; the fill index selects which one captures.
  for (genvar i = 0; i < 2*N; i++) begin : g_elem
    localparam logic [7:0] IDX = 8'(i);
    logic [63:0] q;
    matrix_stream_load_elem u_elem (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && (count == IDX)),
      .d   (in_data),
      .q   (q)
    );
    if (i < N) begin : g_a
      assign op_a[i*64 +: 64] = q;
    end else begin : g_b
      assign op_b[(i-N)*64 +: 64] = q;
    end
  end
endmodule

// File: tb/tb_matrix_stream_load.sv
// Scoreboard bench for matrix_stream_load with SIZE=2 and a bench-driven mul_ready.

module tb_matrix_stream_load;
  localparam int SIZE = 2;
  localparam int N    = SIZE * SIZE;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, clear, mul_ready;
  logic [63:0]             in_data;
  logic                    in_ready, mul_enable, busy, done;
  logic [SIZE*SIZE*64-1:0] op_a, op_b;
  logic [7:0]              count;

  matrix_stream_load #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .op_a(op_a), .op_b(op_b),
    .mul_enable(mul_enable), .mul_ready(mul_ready), .busy(busy),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          exp_cnt = 0;

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; mul_ready = 1'b0; in_data = '0;
    cycle(); cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mul_enable !== 1'b0) begin errors++; $display("FAIL reset_mul_enable got %b want 0", mul_enable); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (op_a !== '0 || op_b !== '0) begin errors++; $display("FAIL reset_ops got %h %h want 0", op_a, op_b); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    exp_cnt = 0;
  endtask

  // Idle for gap cycles, then transfer one word; scoreboard records it.
  task automatic send_word(input logic [63:0] w, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      cycle();
      checks++; if (count !== 8'(exp_cnt)) begin errors++; $display("FAIL gap_count got %0d want %0d", count, exp_cnt); end
    end
    in_valid = 1'b1; in_data = w; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    exp_q.push_back(w);
    exp_cnt = (exp_cnt == 2*N-1) ? 0 : exp_cnt + 1;
    checks++; if (count !== 8'(exp_cnt)) begin errors++; $display("FAIL xfer_count got %0d want %0d", count, exp_cnt); end
  endtask

  task automatic check_ops();
    logic [63:0] w, act;
    checks++;
    if (exp_q.size() != 2*N) begin errors++; $display("FAIL sb_depth got %0d want %0d", exp_q.size(), 2*N); end
    for (int i = 0; i < 2*N && exp_q.size() > 0; i++) begin
      w   = exp_q.pop_front();
      act = (i < N) ? op_a[i*64 +: 64] : op_b[(i-N)*64 +: 64];
      checks++;
      if (act !== w) begin errors++; $display("FAIL elem%0d got %h want %h", i, act, w); end
    end
  endtask

  // Called in S_START; returns in the done cycle.
  task automatic finish_pair(input bit stuck, input int wait_cycles);
    checks++; if (mul_enable !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL start en=%b busy=%b rdy=%b want 1 1 0", mul_enable, busy, in_ready); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL start_count got %0d want 0", count); end
    check_ops();
    cycle();
    checks++; if (mul_enable !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL arm en=%b busy=%b done=%b rdy=%b want 0 1 0 0", mul_enable, busy, done, in_ready); end
    cycle();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL busy1 busy=%b done=%b rdy=%b want 1 0 0", busy, done, in_ready); end
    if (!stuck) begin
      for (int k = 0; k < wait_cycles; k++) begin
        cycle();
        checks++; if (busy !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL busy_wait busy=%b done=%b want 1 0", busy, done); end
      end
      mul_ready = 1'b1;
    end
    cycle();
    if (!stuck) mul_ready = 1'b0;
    checks++; if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL done done=%b rdy=%b busy=%b want 1 1 0", done, in_ready, busy); end
  endtask

  task automatic test_fill_basic();
    for (int k = 1; k <= 2*N; k++) send_word($realtobits(real'(k)), 0);
    finish_pair(1'b0, 3);
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  // Stuck-high ready completes exactly 3 cycles after mul_enable; next pair starts in the done cycle.
  task automatic test_back_to_back();
    mul_ready = 1'b1;
    for (int k = 11; k <= 10 + 2*N; k++) send_word($realtobits(real'(k)), 0);
    finish_pair(1'b1, 0);
    mul_ready = 1'b0;
    send_word($realtobits(100.0), 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done got %b want 0", done); end
  endtask

  task automatic test_clear();
    send_word($realtobits(101.0), 0);
    send_word($realtobits(102.0), 0);
    in_valid = 1'b1; clear = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D;
    cycle();
    in_valid = 1'b0; clear = 1'b0;
    exp_q.delete(); exp_cnt = 0;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL clear_count got %0d want 0", count); end
    for (int k = 0; k < 2*N; k++) send_word($realtobits(real'(200 + k)), 0);
    finish_pair(1'b0, 1);
    cycle();
  endtask

  task automatic test_random_gaps();
    for (int k = 0; k < 2*N; k++) send_word({32'hC0FFEE00, $urandom}, int'($urandom_range(0, 3)));
    finish_pair(1'b0, int'($urandom_range(0, 4)));
    cycle();
  endtask

  task automatic test_rst_busy();
    for (int k = 0; k < 2*N; k++) send_word($realtobits(real'(-k - 1)), k % 2);
    check_ops();
    cycle(); cycle(); cycle();
    rst = 1'b1; mul_ready = 1'b1; #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mul_enable !== 1'b0)
      begin errors++; $display("FAIL rst_force busy=%b rdy=%b en=%b want 0 0 0", busy, in_ready, mul_enable); end
    cycle();
    rst = 1'b0; mul_ready = 1'b0; #1;
    exp_cnt = 0;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL rst_busy cnt=%0d busy=%b rdy=%b done=%b want 0 0 1 0", count, busy, in_ready, done); end
    checks++; if (op_a !== '0 || op_b !== '0) begin errors++; $display("FAIL rst_busy_ops got %h %h want 0", op_a, op_b); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_back_to_back();
    test_clear();
    test_random_gaps();
    test_rst_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_load.md
Name: matrix_stream_load

Overview:
- Upstream feeder for the floating-point matrix multiplier (matrix_mul).
- Accepts IEEE-754 double words one at a time over a valid/ready stream and assembles them into the two packed SIZE x SIZE operand buses, op_a then op_b.
- Once both operands are complete, it pulses the multiplier enable and holds the operands stable until the multiplier reports completion.
- It then signals done and returns to accepting the next operand pair.

Parameters:
- SIZE, default 4: matrix dimension. Legal range 1..11, so that 2*SIZE*SIZE <= 242 fits the 8-bit counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  64  operand element, IEEE-754 double
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- clear  input  1  discard the partially loaded pair and restart the fill
- op_a  output  SIZE*SIZE*64  packed operand A, to the multiplier op_a
- op_b  output  SIZE*SIZE*64  packed operand B, to the multiplier op_b
- mul_enable  output  1  one-cycle start pulse, to the multiplier enable
- mul_ready  input  1  multiplier ready/complete flag
- busy  output  1  operands frozen, multiply in flight
- done  output  1  one-cycle pulse when the multiply completes
- count  output  8  number of words accepted in the current fill

Behaviour:
- States: S_FILL, S_START, S_ARM, S_BUSY. The state register is 2 bits.
- Reset values, applied at the first clk edge with rst high:
  - state = S_FILL, count = 0, op_a = 0, op_b = 0, done = 0.
  - in_ready, mul_enable and busy are forced 0 while rst is high.
- Reset mid-operation in any state aborts immediately with the same values. The multiplier shares rst, so no stale handshake survives.
- in_ready = (state == S_FILL) && !rst. It is combinational, with no dependence on in_valid.
- A transfer occurs on any posedge with in_valid && in_ready.
- Word placement, with N = SIZE*SIZE and e = count at transfer:
  - e < N: word is written to op_a[e*64 +: 64].
  - N <= e < 2N: word is written to op_b[(e-N)*64 +: 64].
  - Element (r, c) is therefore index r*SIZE + c, row-major, with element (0,0) in the LSBs.
  - Unwritten elements retain their previous values.
- S_FILL:
  - clear high: count <= 0 and the state stays S_FILL. clear has priority over a simultaneous transfer, and that word is dropped, not stored. op_a/op_b are not zeroed.
  - Transfer with e < 2N-1: count <= count + 1.
  - Transfer with e == 2N-1: the word is stored, count <= 0, state <= S_START.
  - No transfer: the state holds.
- S_START (exactly 1 cycle):
  - mul_enable = 1 (decoded from state) and busy = 1.
  - Next state S_ARM.
- S_ARM (exactly 1 cycle):
  - busy = 1. mul_ready is ignored, because the multiplier lowers ready only at the edge after it samples enable and a stale high from the previous run must not be taken as completion.
  - Next state S_BUSY.
- S_BUSY:
  - busy = 1.
  - If mul_ready is sampled 1: done <= 1 for one cycle, and state <= S_FILL.
  - Otherwise the state holds, with no timeout.
- done is registered. It is high during the first S_FILL cycle after completion and is otherwise 0.
- clear is ignored outside S_FILL.
- op_a and op_b are never modified outside S_FILL, so they are stable from the S_START cycle until done.
- Latency:
  - Last input transfer to mul_enable high: 1 cycle.
  - mul_ready high in S_BUSY to done high and in_ready high: 1 cycle, with the two coinciding.
- Back-to-back: a new word may be accepted in the same cycle done is high.
- Minimum cycle count per matrix pair: 2N transfers + 2 (S_START, S_ARM) + multiplier time.

Test Plan:
- SIZE=2, rst 2 cycles, then 8 words 1.0 .. 8.0 with in_valid held high -> op_a = {4.0, 3.0, 2.0, 1.0} (MSB to LSB) and op_b = {8.0, 7.0, 6.0, 5.0}; count steps 0..7 then 0; mul_enable is high for exactly 1 cycle, 1 cycle after the 8th transfer; in_ready is 0 until done.
- mul_ready held 1 throughout and stuck high from the previous run -> the block does not finish in S_ARM; it completes only at the S_BUSY sample, so done appears exactly 3 cycles after mul_enable.
- Connected to matrix_mul with A = identity and B = {1, 2, 3, 4} -> the multiplier prod equals B, and done pulses once per run.
- in_valid toggling every other cycle with random gaps -> data packs in arrival order with no duplicates or drops, and count only advances on transfers.
- clear asserted after 3 transfers, together with an in_valid word -> count = 0, that word is not stored, and the next 8 words start again at op_a element 0.
- rst asserted during S_BUSY -> the next cycle has count = 0, op_a = op_b = 0, busy = 0, in_ready = 1, and no done pulse.
